fft_output_serializer: RTL and testbench
========================================

Name: fft_output_serializer

Overview:
- Parametrised successor to the FFT output unit.
- Captures one FFT frame of N = LANES*BEATS complex samples, arriving LANES samples per beat over BEATS beats from the last butterfly stage.
- Streams the frame out one complex sample per accepted handshake.
- Adds valid/ready back-pressure, frame-last marking, a sample index output, start-overrun detection and optional bit-reversed read-out.

Parameters:
- DW, 10, bit width of each real/imag component.
- LANES, 8, samples per input beat; power of two, >=2.
- BEATS, 8, input beats per frame; power of two, >=2.
- Derived localparams (not overridable): N = LANES*BEATS; IDX_W = $clog2(N); BW = $clog2(BEATS).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_send  in  1  single-cycle pulse; arms capture of a new frame.
- din_valid  in  1  current beat on dinre/dinim is valid.
- dinre  in  LANES*DW  real parts; lane l occupies bits [l*DW +: DW].
- dinim  in  LANES*DW  imaginary parts; same packing as dinre.
- dout_re  out  DW  real part of the current output sample.
- dout_im  out  DW  imaginary part of the current output sample.
- dout_valid  out  1  output sample valid.
- dout_ready  in  1  downstream accepts the sample.
- dout_last  out  1  high with the final sample of a frame (index N-1 in send order).
- dout_index  out  IDX_W  natural frequency-bin index of the current sample.
- men  out  1  high throughout SEND; kept for existing consumers.
- busy  out  1  high in LOAD or SEND.
- start_drop  out  1  one-cycle pulse when start_send arrives outside IDLE.

Behaviour:
- Reset values: state IDLE; all counters 0; all outputs 0; storage cleared to 0.
- Reset mid-frame aborts immediately. The next frame needs a fresh start_send.
- State IDLE:
  - start_send -> LOAD; beat counter cleared.
  - din_valid in the start cycle is ignored.
- State LOAD:
  - Each cycle with din_valid high captures one beat b (beat counter value).
  - Lane l of beat b is written to storage slot k = l*BEATS + b.
  - Cycles without din_valid stall the load; no timeout.
  - After capturing beat BEATS-1 -> SEND on the next clock; read index cleared.
- State SEND:
  - dout_valid = 1 and men = 1.
  - The output sample is storage[slot(rd_idx)].
  - rd_idx advances only on dout_valid && dout_ready.
  - dout_re/dout_im/dout_index/dout_last hold stable while dout_valid && !dout_ready.
  - Handshake with rd_idx == N-1 (dout_last=1) -> IDLE; dout_valid drops on the next cycle.
- Output timing:
  - dout_* are combinational reads of registered storage indexed by registered rd_idx.
  - First sample is valid in the cycle after the final LOAD capture.
  - With ready held high, throughput is 1 sample/cycle and a full frame takes N cycles.
- dout_index = slot(rd_idx). Default slot(i) = i, i.e. lane-major order: lane 0 beats 0..BEATS-1, then lane 1, and so on.
- start_send while busy:
  - Ignored; start_drop pulses for one cycle.
  - The current frame is unaffected.
- start_send in the same cycle as the final SEND handshake:
  - Ignored and flagged, because the state is still SEND.
- No arithmetic is performed. Data passes through bit-exact; DW is unchanged.
- dout_ready is don't-care outside SEND.

Optional Feature:
- Macro: FFT_OUT_BITREV_EN.
- Defined:
  - slot(i) = bit-reverse of i over IDX_W bits, so the frame is emitted in reversed-index order and dout_index reports the reversed index.
  - dout_last is still tied to the N-th handshake, not to the index value.
- Undefined: slot(i) = i, with no reversal logic synthesised.

Decomposition:
- Shared package fft_pkg holds:
  - FFT_DW = 10, FFT_LANES = 8, FFT_BEATS = 8 defaults.
  - The state encoding constants ST_IDLE = 2'b00, ST_LOAD = 2'b01, ST_SEND = 2'b10, shared with the other FFT control FSMs.
  - A bitrev function parameterised by width.
- One natural sub-module: fft_frame_buffer.
  - N x 2*DW register array.
  - Write port: LANES-wide, per beat.
  - Single read port indexed by slot.
  - Async reset clear.
- The serializer holds the FSM, counters and handshake logic.

Test Plan:
- Basic frame, defaults, macro off:
  - Stimulus: start_send, then 8 consecutive beats with lane l of beat b = re 10*l+b, im -(10*l+b); ready tied high.
  - Response: 64 samples on consecutive cycles, dout_re at step k equals 10*(k/8)+(k%8), dout_index = k, dout_last only at k = 63, then IDLE.
- Back-pressure:
  - Stimulus: same frame with dout_ready toggling 1,0,0,1.
  - Response: outputs hold on ready=0, no sample skipped or duplicated, exactly 64 handshakes.
- Load gaps:
  - Stimulus: din_valid pattern 1,0,1,1,0,0,1,1,1,1.
  - Response: exactly 8 beats captured in order; SEND entered the cycle after the 8th valid beat.
- Start overrun:
  - Stimulus: start_send pulsed at send step 20.
  - Response: start_drop = 1 for one cycle, frame completes unchanged, busy falls after step 63.
- Reset mid-SEND:
  - Stimulus: assert rst_n = 0 at send step 30.
  - Response: dout_valid, men, busy = 0 immediately; a new frame after reset streams correctly from index 0.
- FFT_OUT_BITREV_EN defined, defaults:
  - Response: send step 1 gives dout_index = 32, step 2 gives 16, step 63 gives 63; data matches storage[bitrev(k)].

Source files
------------

// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_pkg
// Description : Shared FFT definitions. Default geometry, the control-FSM
//               state encoding used by all FFT control blocks, and a
//               width-parameterised bit-reverse helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

  localparam int FFT_DW    = 10;
  localparam int FFT_LANES = 8;
  localparam int FFT_BEATS = 8;

  // Encoding is shared with the other FFT control FSMs; keep values fixed.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_SEND = 2'b10
  } fft_state_t;

  // Reverse the low 'width' bits of value; upper bits of the result are zero.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < width; i++) begin
      r[5'(i)] = value[5'(width - 1 - i)];
    end
    return r;
  endfunction

endpackage : fft_pkg
`default_nettype wire

// File: rtl/fft_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fft_frame_buffer
// Description : N-entry complex sample store for one FFT frame. A full beat
//               of LANES samples is written per cycle; lane l of beat b lands
//               in slot l*BEATS + b. One combinational read port by slot.
//               Storage is cleared by the asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_frame_buffer #(
  parameter  int DW    = 10,
  parameter  int LANES = 8,
  parameter  int BEATS = 8,
  localparam int N     = LANES * BEATS,
  localparam int IDX_W = $clog2(N),
  localparam int BW    = $clog2(BEATS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [BW-1:0]         wr_beat,
  input  logic [LANES*DW-1:0]   wr_re,
  input  logic [LANES*DW-1:0]   wr_im,
  input  logic [IDX_W-1:0]      rd_slot,
  output logic [DW-1:0]         rd_re,
  output logic [DW-1:0]         rd_im
);

  // Each word holds {re, im}.
  logic [2*DW-1:0] r_mem [N];

  // Beat write: every slot whose beat column matches takes its lane's sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        r_mem[IDX_W'(k)] <= '0;
      end
    end else if (wr_en) begin
      for (int k = 0; k < N; k++) begin
        if (BW'(k % BEATS) == wr_beat) begin
          r_mem[IDX_W'(k)] <= {wr_re[(k / BEATS) * DW +: DW],
                               wr_im[(k / BEATS) * DW +: DW]};
        end
      end
    end
  end

  assign {rd_re, rd_im} = r_mem[rd_slot];

endmodule : fft_frame_buffer
`default_nettype wire

// File: rtl/fft_output_serializer.sv
`default_nettype none
// ============================================================================
// Module      : fft_output_serializer
// Description : Captures one FFT frame (LANES samples per beat, BEATS beats)
//               and streams it out one complex sample per valid/ready
//               handshake, with frame-last marking, a frequency-bin index,
//               and start-overrun flagging.
//               Build option: define FFT_OUT_BITREV_EN to emit the frame in
//               bit-reversed index order.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_output_serializer
  import fft_pkg::*;
#(
  parameter  int DW    = FFT_DW,
  parameter  int LANES = FFT_LANES,
  parameter  int BEATS = FFT_BEATS,
  localparam int N     = LANES * BEATS,
  localparam int IDX_W = $clog2(N),
  localparam int BW    = $clog2(BEATS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_send,
  input  logic                  din_valid,
  input  logic [LANES*DW-1:0]   dinre,
  input  logic [LANES*DW-1:0]   dinim,
  output logic [DW-1:0]         dout_re,
  output logic [DW-1:0]         dout_im,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_last,
  output logic [IDX_W-1:0]      dout_index,
  output logic                  men,
  output logic                  busy,
  output logic                  start_drop
);

  fft_state_t         r_state;
  logic [BW-1:0]      r_beat;
  logic [IDX_W-1:0]   r_rd_idx;
  logic               r_dout_valid;
  logic               r_men;
  logic               r_busy;
  logic               r_start_drop;

  logic               w_wr_en;
  logic [IDX_W-1:0]   w_slot;
  logic               w_rd_last;

  assign w_wr_en   = (r_state == ST_LOAD) && din_valid;
  assign w_rd_last = (r_rd_idx == IDX_W'(N - 1));

`ifdef FFT_OUT_BITREV_EN
  assign w_slot = IDX_W'(bitrev(32'(r_rd_idx), IDX_W));
`else
  assign w_slot = r_rd_idx;
`endif

  fft_frame_buffer #(
    .DW    (DW),
    .LANES (LANES),
    .BEATS (BEATS)
  ) u_frame_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (w_wr_en),
    .wr_beat (r_beat),
    .wr_re   (dinre),
    .wr_im   (dinim),
    .rd_slot (w_slot),
    .rd_re   (dout_re),
    .rd_im   (dout_im)
  );

  // Control FSM: load beats, then stream samples; status outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_beat       <= '0;
      r_rd_idx     <= '0;
      r_dout_valid <= 1'b0;
      r_men        <= 1'b0;
      r_busy       <= 1'b0;
      r_start_drop <= 1'b0;
    end else begin
      // A start outside IDLE never disturbs the frame in flight.
      r_start_drop <= start_send && (r_state != ST_IDLE);
      unique case (r_state)
        ST_IDLE: begin
          if (start_send) begin
            r_state <= ST_LOAD;
            r_beat  <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (din_valid) begin
            r_beat <= r_beat + BW'(1);
            if (r_beat == BW'(BEATS - 1)) begin
              r_state      <= ST_SEND;
              r_rd_idx     <= '0;
              r_dout_valid <= 1'b1;
              r_men        <= 1'b1;
            end
          end
        end
        ST_SEND: begin
          if (dout_ready) begin
            if (w_rd_last) begin
              r_state      <= ST_IDLE;
              r_rd_idx     <= '0;
              r_dout_valid <= 1'b0;
              r_men        <= 1'b0;
              r_busy       <= 1'b0;
            end else begin
              r_rd_idx <= r_rd_idx + IDX_W'(1);
            end
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_dout_valid <= 1'b0;
          r_men        <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign dout_valid = r_dout_valid;
  assign dout_last  = r_dout_valid && w_rd_last;
  assign dout_index = w_slot;
  assign men        = r_men;
  assign busy       = r_busy;
  assign start_drop = r_start_drop;

endmodule : fft_output_serializer
`default_nettype wire

// File: tb/tb_fft_output_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_output_serializer
// Description : Self-checking bench for fft_output_serializer. Expected
//               samples are queued when a frame is loaded and compared as
//               the serializer hands them out.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_output_serializer;

  localparam int DW    = 10;
  localparam int LANES = 8;
  localparam int BEATS = 8;
  localparam int N     = LANES * BEATS;
  localparam int IDX_W = $clog2(N);

  typedef struct {
    logic [DW-1:0]    re;
    logic [DW-1:0]    im;
    logic [IDX_W-1:0] idx;
    logic             last;
  } exp_t;

  logic                clk;
  logic                rst_n;
  logic                start_send;
  logic                din_valid;
  logic [LANES*DW-1:0] dinre;
  logic [LANES*DW-1:0] dinim;
  logic [DW-1:0]       dout_re;
  logic [DW-1:0]       dout_im;
  logic                dout_valid;
  logic                dout_ready;
  logic                dout_last;
  logic [IDX_W-1:0]    dout_index;
  logic                men;
  logic                busy;
  logic                start_drop;

  exp_t sb[$];
  int   n_checks;
  int   n_pass;
  int   hs_total;

  fft_output_serializer #(
    .DW    (DW),
    .LANES (LANES),
    .BEATS (BEATS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_send (start_send),
    .din_valid  (din_valid),
    .dinre      (dinre),
    .dinim      (dinim),
    .dout_re    (dout_re),
    .dout_im    (dout_im),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .dout_index (dout_index),
    .men        (men),
    .busy       (busy),
    .start_drop (start_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Send-order to storage-slot mapping of the reference model.
  function automatic int model_slot(input int k);
`ifdef FFT_OUT_BITREV_EN
    int r;
    r = 0;
    for (int i = 0; i < IDX_W; i++) begin
      if (((k >> i) & 1) != 0) r = r | (1 << (IDX_W - 1 - i));
    end
    return r;
`else
    return k;
`endif
  endfunction

  // Handshake monitor and output-stability checker, sampled on the falling edge.
  logic             prev_stall;
  logic [DW-1:0]    prev_re;
  logic [DW-1:0]    prev_im;
  logic [IDX_W-1:0] prev_idx;
  logic             prev_last;
  initial prev_stall = 1'b0;
  initial hs_total = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && dout_valid) begin
        check("hold_re", 32'(dout_re), 32'(prev_re));
        check("hold_im", 32'(dout_im), 32'(prev_im));
        check("hold_index", 32'(dout_index), 32'(prev_idx));
        check("hold_last", 32'(dout_last), 32'(prev_last));
      end
      if (dout_valid && dout_ready) begin
        hs_total = hs_total + 1;
        if (sb.size() == 0) begin
          check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          check("dout_re", 32'(dout_re), 32'(e.re));
          check("dout_im", 32'(dout_im), 32'(e.im));
          check("dout_index", 32'(dout_index), 32'(e.idx));
          check("dout_last", 32'(dout_last), 32'(e.last));
          check("men_send", 32'(men), 32'd1);
        end
      end
      prev_stall = dout_valid && !dout_ready;
      prev_re    = dout_re;
      prev_im    = dout_im;
      prev_idx   = dout_index;
      prev_last  = dout_last;
    end
  end

  // Load one frame: lane l of beat b carries base+10*l+b (im is its negation).
  task automatic load_frame(input int base, input bit gaps);
    bit pat [10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    int b;
    int cyc;
    for (int k = 0; k < N; k++) begin
      exp_t e;
      int   s;
      logic [DW-1:0] v;
      s = model_slot(k);
      v = DW'(base + 10 * (s / BEATS) + (s % BEATS));
      e.re   = v;
      e.im   = -v;
      e.idx  = IDX_W'(s);
      e.last = (k == N - 1);
      sb.push_back(e);
    end
    @(posedge clk); #1;
    start_send = 1'b1;
    din_valid  = 1'b1;
    dinre      = '1;
    dinim      = '1;
    @(posedge clk); #1;
    start_send = 1'b0;
    din_valid  = 1'b0;
    check("busy_load", 32'(busy), 32'd1);
    b   = 0;
    cyc = 0;
    while (b < BEATS) begin
      check("valid_in_load", 32'(dout_valid), 32'd0);
      if (!gaps || pat[cyc % 10]) begin
        din_valid = 1'b1;
        for (int l = 0; l < LANES; l++) begin
          logic [DW-1:0] v;
          v = DW'(base + 10 * l + b);
          dinre[l*DW +: DW] = v;
          dinim[l*DW +: DW] = -v;
        end
        b++;
      end else begin
        din_valid = 1'b0;
        dinre     = '1;
        dinim     = '1;
      end
      cyc++;
      @(posedge clk); #1;
    end
    din_valid = 1'b0;
    check("send_entry", 32'(dout_valid), 32'd1);
  endtask

  // Stream the frame; optional overrun pulse or reset at a given send step.
  task automatic send_frame(input int ready_mode, input int overrun_at,
                            input int reset_at, output bit aborted);
    bit rpat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int start_hs;
    int cycles;
    bit ov_pend;
    bit ov_post;
    bit ov_done;
    start_hs = hs_total;
    cycles   = 0;
    ov_pend  = 1'b0;
    ov_post  = 1'b0;
    ov_done  = 1'b0;
    aborted  = 1'b0;
    while (hs_total - start_hs < N) begin
      if (cycles > 2000) begin
        check("send_timeout", 32'(hs_total - start_hs), 32'(N));
        break;
      end
      if (ov_pend) begin
        check("start_drop_pulse", 32'(start_drop), 32'd1);
        start_send = 1'b0;
        ov_pend    = 1'b0;
        ov_post    = 1'b1;
      end else if (ov_post) begin
        check("start_drop_clear", 32'(start_drop), 32'd0);
        ov_post = 1'b0;
      end
      if (reset_at >= 0 && (hs_total - start_hs) == reset_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_dout_valid", 32'(dout_valid), 32'd0);
        check("rst_men", 32'(men), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dout_last", 32'(dout_last), 32'd0);
        sb.delete();
        aborted = 1'b1;
        break;
      end
      if (overrun_at >= 0 && !ov_done && (hs_total - start_hs) == overrun_at) begin
        start_send = 1'b1;
        ov_pend    = 1'b1;
        ov_done    = 1'b1;
      end
      dout_ready = (ready_mode == 0) ? 1'b1 : rpat[cycles % 4];
      @(posedge clk); #1;
      cycles++;
    end
    if (!aborted) begin
      if (ready_mode == 0) check("frame_cycles", 32'(cycles), 32'(N));
      check("end_dout_valid", 32'(dout_valid), 32'd0);
      check("end_busy", 32'(busy), 32'd0);
      check("end_men", 32'(men), 32'd0);
      check("end_sb_empty", 32'(sb.size()), 32'd0);
      if (overrun_at >= 0) check("overrun_seen", 32'(ov_done), 32'd1);
    end
    dout_ready = 1'b1;
  endtask

  initial begin
    bit ab;
    n_checks   = 0;
    n_pass     = 0;
    rst_n      = 1'b0;
    start_send = 1'b0;
    din_valid  = 1'b0;
    dinre      = '0;
    dinim      = '0;
    dout_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 32'(dout_valid), 32'd0);
    check("reset_men", 32'(men), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_drop", 32'(start_drop), 32'd0);
    check("reset_last", 32'(dout_last), 32'd0);
    check("reset_re", 32'(dout_re), 32'd0);
    check("reset_im", 32'(dout_im), 32'd0);
    check("reset_index", 32'(dout_index), 32'd0);
    rst_n = 1'b1;

    load_frame(0, 1'b0);
    send_frame(0, -1, -1, ab);

    load_frame(100, 1'b0);
    send_frame(1, -1, -1, ab);

    load_frame(200, 1'b1);
    send_frame(0, -1, -1, ab);

    load_frame(300, 1'b0);
    send_frame(0, 20, -1, ab);

    load_frame(50, 1'b0);
    send_frame(0, -1, 30, ab);
    check("reset_abort_taken", 32'(ab), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #2;
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_valid", 32'(dout_valid), 32'd0);
    check("post_rst_re", 32'(dout_re), 32'd0);
    check("post_rst_index", 32'(dout_index), 32'd0);

    load_frame(150, 1'b0);
    send_frame(1, -1, -1, ab);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_fft_output_serializer
`default_nettype wire
